// File: rtl/gear_button_conditioner.sv
// ============================================================================
// gear_button_conditioner: synchronise, debounce and arbitrate gearbox buttons
// Revision: 1.0
// ============================================================================
`default_nettype none

module gear_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PULSE_CYCLES    = 50_000_000,
  parameter int GAP_CYCLES      = 50_000_000,
  parameter int CNT_W           = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_brake,
  output logic shift_up,
  output logic shift_down,
  output logic brake,
  output logic busy
);

  localparam logic [CNT_W-1:0] c_deb_last   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_pulse_last = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_gap_last   = CNT_W'(GAP_CYCLES - 1);
  localparam int               c_up         = 0;
  localparam int               c_dn         = 1;
  localparam int               c_brk        = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE_UP = 2'd1,
    PULSE_DN = 2'd2,
    GAP      = 2'd3
  } state_t;

  logic [2:0]       btn_raw;
  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  logic [2:0]       deb_q, deb_d;
  logic [2:0]       deb_prev_q, deb_prev_d;
  logic [CNT_W-1:0] db_cnt_q [3];
  logic [CNT_W-1:0] db_cnt_d [3];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             shift_up_q, shift_up_d;
  logic             shift_down_q, shift_down_d;
  logic             brake_q, brake_d;
  logic             busy_q, busy_d;

  logic             up_evt;
  logic             dn_evt;

  assign btn_raw = {btn_brake, btn_down, btn_up};

  // Debounce: counter only runs while the synced level disagrees with the accepted one.
  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == c_deb_last) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign up_evt = deb_q[c_up] & ~deb_prev_q[c_up];
  assign dn_evt = deb_q[c_dn] & ~deb_prev_q[c_dn];

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (up_evt && !dn_evt && !deb_q[c_brk]) begin
          state_d = PULSE_UP;
        end else if (dn_evt && !up_evt) begin
          state_d = PULSE_DN;
        end
      end
      PULSE_UP, PULSE_DN: begin
        if (phase_q == c_pulse_last) begin
          state_d = GAP;
          phase_d = '0;
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (phase_q == c_gap_last) begin
          state_d = IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  always_comb begin
    shift_up_d   = (state_d == PULSE_UP);
    shift_down_d = (state_d == PULSE_DN);
    brake_d      = deb_q[c_brk];
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_q        <= '0;
      deb_prev_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
      state_q      <= IDLE;
      phase_q      <= '0;
      shift_up_q   <= 1'b0;
      shift_down_q <= 1'b0;
      brake_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      deb_q        <= deb_d;
      deb_prev_q   <= deb_prev_d;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      state_q      <= state_d;
      phase_q      <= phase_d;
      shift_up_q   <= shift_up_d;
      shift_down_q <= shift_down_d;
      brake_q      <= brake_d;
      busy_q       <= busy_d;
    end
  end

  assign shift_up   = shift_up_q;
  assign shift_down = shift_down_q;
  assign brake      = brake_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_gear_button_conditioner.sv
// ============================================================================
// tb_gear_button_conditioner: scenario bench with a per-cycle expectation queue
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gear_button_conditioner;

  localparam int D = 4;
  localparam int P = 8;
  localparam int G = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic btn_brake = 1'b0;
  logic shift_up, shift_down, brake, busy;

  int n_cmp = 0;
  int n_bad = 0;

  // stim = {reset, btn_brake, btn_down, btn_up}; exp = {shift_up, shift_down, brake, busy}
  typedef struct packed {
    logic [3:0] stim;
    logic [3:0] exp;
  } item_t;

  item_t sb_q[$];

  gear_button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .PULSE_CYCLES   (P),
    .GAP_CYCLES     (G),
    .CNT_W          (26)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_brake (btn_brake),
    .shift_up  (shift_up),
    .shift_down(shift_down),
    .brake     (brake),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic item_t mk(logic rst, logic brk, logic dn, logic up,
                               logic su, logic sd, logic bk, logic by);
    item_t it;
    it.stim = {rst, brk, dn, up};
    it.exp  = {su, sd, bk, by};
    return it;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    {btn_brake, btn_down, btn_up} = 3'b000;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    {btn_brake, btn_down, btn_up} = 3'b111;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if ({shift_up, shift_down, brake, busy} !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset cycle %0d: got %b want 0000", c,
                 {shift_up, shift_down, brake, busy});
      end
    end
  endtask

  task automatic test_single_up();
    item_t it;
    for (int c = 0; c < 30; c++)
      sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1,
                        (c >= 7 && c <= 14), 1'b0, 1'b0, (c >= 7 && c <= 22)));
    for (int c = 0; sb_q.size() > 0; c++) begin
      it = sb_q.pop_front();
      {reset, btn_brake, btn_down, btn_up} = it.stim;
      n_cmp++;
      if ({shift_up, shift_down, brake, busy} !== it.exp) begin
        n_bad++;
        $display("FAIL single_up cycle %0d: got %b want %b", c,
                 {shift_up, shift_down, brake, busy}, it.exp);
      end
      tick();
    end
  endtask

  task automatic test_bounce_down();
    item_t it;
    logic  dn;
    for (int c = 0; c < 40; c++) begin
      dn = (c == 0 || c == 2 || c >= 4);
      sb_q.push_back(mk(1'b0, 1'b0, dn, 1'b0,
                        1'b0, (c >= 11 && c <= 18), 1'b0, (c >= 11 && c <= 26)));
    end
    for (int c = 0; sb_q.size() > 0; c++) begin
      it = sb_q.pop_front();
      {reset, btn_brake, btn_down, btn_up} = it.stim;
      n_cmp++;
      if ({shift_up, shift_down, brake, busy} !== it.exp) begin
        n_bad++;
        $display("FAIL bounce_down cycle %0d: got %b want %b", c,
                 {shift_up, shift_down, brake, busy}, it.exp);
      end
      tick();
    end
  endtask

  task automatic test_brake_inhibit();
    item_t it;
    for (int c = 0; c < 50; c++)
      sb_q.push_back(mk(1'b0, 1'b1, (c >= 20), (c >= 10 && c < 25),
                        1'b0, (c >= 27 && c <= 34), (c >= 7), (c >= 27 && c <= 42)));
    for (int c = 0; sb_q.size() > 0; c++) begin
      it = sb_q.pop_front();
      {reset, btn_brake, btn_down, btn_up} = it.stim;
      n_cmp++;
      if ({shift_up, shift_down, brake, busy} !== it.exp) begin
        n_bad++;
        $display("FAIL brake_inhibit cycle %0d: got %b want %b", c,
                 {shift_up, shift_down, brake, busy}, it.exp);
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    item_t it;
    for (int c = 0; c < 30; c++)
      sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int c = 0; sb_q.size() > 0; c++) begin
      it = sb_q.pop_front();
      {reset, btn_brake, btn_down, btn_up} = it.stim;
      n_cmp++;
      if ({shift_up, shift_down, brake, busy} !== it.exp) begin
        n_bad++;
        $display("FAIL simultaneous cycle %0d: got %b want %b", c,
                 {shift_up, shift_down, brake, busy}, it.exp);
      end
      tick();
    end
  endtask

  // First press accepted, second press debounces inside GAP, third after busy falls.
  task automatic test_back_to_back();
    item_t it;
    logic  up;
    for (int c = 0; c < 56; c++) begin
      up = (c <= 4) || (c >= 12 && c < 20) || (c >= 30);
      sb_q.push_back(mk(1'b0, 1'b0, 1'b0, up,
                        (c >= 7 && c <= 14) || (c >= 37 && c <= 44), 1'b0, 1'b0,
                        (c >= 7 && c <= 22) || (c >= 37 && c <= 52)));
    end
    for (int c = 0; sb_q.size() > 0; c++) begin
      it = sb_q.pop_front();
      {reset, btn_brake, btn_down, btn_up} = it.stim;
      n_cmp++;
      if ({shift_up, shift_down, brake, busy} !== it.exp) begin
        n_bad++;
        $display("FAIL back_to_back cycle %0d: got %b want %b", c,
                 {shift_up, shift_down, brake, busy}, it.exp);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_pulse();
    item_t it;
    logic  on;
    for (int c = 0; c < 40; c++) begin
      on = (c >= 7 && c <= 10) || (c >= 22 && c <= 29);
      sb_q.push_back(mk((c >= 10 && c <= 14), 1'b0, 1'b0, 1'b1,
                        on, 1'b0, 1'b0, (c >= 7 && c <= 10) || (c >= 22 && c <= 37)));
    end
    for (int c = 0; sb_q.size() > 0; c++) begin
      it = sb_q.pop_front();
      {reset, btn_brake, btn_down, btn_up} = it.stim;
      n_cmp++;
      if ({shift_up, shift_down, brake, busy} !== it.exp) begin
        n_bad++;
        $display("FAIL reset_mid_pulse cycle %0d: got %b want %b", c,
                 {shift_up, shift_down, brake, busy}, it.exp);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    test_reset();
    apply_reset();
    test_single_up();
    apply_reset();
    test_bounce_down();
    apply_reset();
    test_brake_inhibit();
    apply_reset();
    test_simultaneous();
    apply_reset();
    test_back_to_back();
    apply_reset();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
